bus_dev_port: RTL
=================

BUS_DEV_PORT -- requirements
Module: bus_dev_port

Interface
REQ-001 The block SHALL have parameter pckg_sz, default 16, meaning packet width in bits; the top 8 bits are the destination address, the rest are payload.
REQ-002 The block SHALL have parameter depth, default 8, meaning TX and RX FIFO entries (power of 2, >=2).
REQ-003 The block SHALL have parameter id, default 0, meaning this device's 8-bit address.
REQ-004 The block SHALL have parameter broadcast, default 8'hFF, meaning the broadcast address.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have the following device-side TX ports:
- tx_valid, input, 1 bit;
- tx_data, input, pckg_sz bits;
- tx_ready, output, 1 bit.
REQ-008 The block SHALL have the following bus-side TX ports:
- pndng, output, 1 bit: TX FIFO non-empty;
- D_pop, output, pckg_sz bits: TX head;
- pop, input, 1 bit: bus consumes the head.
REQ-009 The block SHALL have the following bus-side RX ports:
- push, input, 1 bit;
- D_push, input, pckg_sz bits.
REQ-010 The block SHALL have the following device-side RX ports:
- rx_valid, output, 1 bit;
- rx_data, output, pckg_sz bits;
- rx_ready, input, 1 bit.
REQ-011 The block SHALL have the following status ports:
- rx_drop_cnt, output, 8 bits: saturating count of packets dropped because the RX FIFO was full;
- pop_err, output, 1 bit: sticky flag for a pop while empty.

Function
REQ-012 The TX write handshake SHALL complete on a clock edge with tx_valid && tx_ready.
REQ-013 tx_ready SHALL equal !tx_full, derived from registered count only, so a simultaneous pop never admits a write into a full FIFO.
REQ-014 The TX FIFO SHALL be show-ahead:
- D_pop SHALL equal the head entry whenever pndng=1;
- pndng SHALL rise one cycle after the first accepted write.
REQ-015 pop with pndng=1 SHALL advance the head on that edge; D_pop SHALL show the next entry, or pndng SHALL fall if the FIFO is now empty.
REQ-016 pop with pndng=0 SHALL be ignored (no pointer change) and SHALL set pop_err until reset.
REQ-017 Simultaneous write and valid pop SHALL both take effect, leaving the count unchanged.
REQ-018 Simultaneous write and pop on an empty FIFO SHALL accept the write and apply REQ-016 to the pop.
REQ-019 On push, the packet SHALL be written to the RX FIFO if the RX FIFO is not full and it passes address filtering (REQ-028).
- A full RX FIFO SHALL drop the packet and increment rx_drop_cnt, saturating at 255.
- rx_valid SHALL rise one cycle after the write.
REQ-020 The RX FIFO SHALL be show-ahead.
- rx_data SHALL be valid while rx_valid=1.
- rx_valid && rx_ready SHALL dequeue.
- Push and dequeue in the same cycle SHALL both take effect, including when the FIFO is full: the dequeue frees an entry, so the push is accepted and not dropped.
REQ-021 Pointer and count arithmetic:
- pointers SHALL wrap modulo depth;
- counts SHALL be $clog2(depth)+1 bits;
- overflow and underflow of the count SHALL be impossible by construction.

Reset
REQ-022 Reset assertion SHALL immediately clear all pointers and counts; D_pop and rx_data are don't-care.
REQ-023 While reset is asserted:
- pndng=0, rx_valid=0, tx_ready=1 (visible immediately on reset assertion);
- rx_drop_cnt=0, pop_err=0;
- handshake inputs SHALL be ignored.
REQ-024 Reset asserted mid-operation SHALL discard all queued packets in both directions.
REQ-025 FIFO storage SHALL NOT require reset.

Configuration
REQ-026 Address filtering SHALL be controlled by the macro BUS_DEV_ADDR_FILTER_EN.
REQ-027 Without BUS_DEV_ADDR_FILTER_EN, every pushed packet SHALL be a candidate for RX.
REQ-028 With BUS_DEV_ADDR_FILTER_EN defined, only packets whose D_push[pckg_sz-1 -: 8] equals id or broadcast SHALL be accepted; others SHALL be discarded silently, without affecting rx_drop_cnt.

Structure
REQ-029 Package bus_dev_pkg SHALL hold:
- ADDR_W=8;
- the default broadcast constant;
- a function extracting the address field from a packet.
REQ-030 The block SHALL contain one sub-module, bus_dev_fifo (parameters width and depth; show-ahead; push/pop/full/empty/count), instantiated twice for TX and RX.

Verification
REQ-031 Write 16'h01AA, 16'h02BB, no pop -> pndng=1 one cycle after the first write, and D_pop=16'h01AA; one pop -> D_pop=16'h02BB; second pop -> pndng=0.
REQ-032 Write 8 packets with depth=8 -> tx_ready=0; write plus pop in the same cycle -> write refused, count 7; next write accepted.
REQ-033 pop while pndng=0 -> pop_err=1, pointers unchanged; reset -> pop_err=0.
REQ-034 Fill RX with rx_ready=0, then push 3 more -> rx_drop_cnt=3; repeat 300 times -> rx_drop_cnt stays 255.
REQ-035 With BUS_DEV_ADDR_FILTER_EN and id=2:
- push 16'h0255 -> accepted;
- push 16'hFF11 -> accepted;
- push 16'h0377 -> not queued, and rx_drop_cnt unchanged.
REQ-036 Queue 4 TX and 4 RX packets, then assert reset for 1 ns mid-cycle -> pndng=0, rx_valid=0, tx_ready=1 immediately; no stale data after release.

Source files
------------

// File: rtl/bus_dev_pkg.sv
// Shared constants and helpers for the bus device port.
// The address field is the top ADDR_W bits of every packet.
package bus_dev_pkg;

  localparam int ADDR_W = 8;
  localparam logic [ADDR_W-1:0] BROADCAST_DEFAULT = 8'hFF;
  // Widest packet the address helper can take; narrower packets are zero-extended.
  localparam int MAX_PKT_W = 256;

  function automatic logic [ADDR_W-1:0] pkt_addr(
    input logic [MAX_PKT_W-1:0] pkt,
    input int unsigned          pkt_w
  );
    return ADDR_W'(pkt >> (pkt_w - ADDR_W));
  endfunction

endpackage

// File: rtl/bus_dev_fifo.sv
// Show-ahead FIFO: o_data is the head entry whenever o_empty is low.
// A pop is ignored while empty; a push into a full FIFO is accepted only alongside a valid pop.
module bus_dev_fifo #(
  parameter int width = 16,
  parameter int depth = 8,
  localparam int AW   = $clog2(depth),
  localparam int CW   = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [width-1:0] i_data,
  input  logic             i_pop,
  output logic [width-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);

  logic [width-1:0] r_mem [depth];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_rd;
  logic             w_wr;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(depth));
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];

  // A full FIFO takes a write only when the same edge frees the head slot.
  assign w_rd = i_pop && !o_empty;
  assign w_wr = i_push && (!o_full || w_rd);

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/bus_dev_port.sv
// Bus device port: TX FIFO toward the bus, RX FIFO toward the device, drop/underflow status.
// Define BUS_DEV_ADDR_FILTER_EN to accept only packets addressed to id or broadcast.
module bus_dev_port
  import bus_dev_pkg::*;
#(
  parameter int               pckg_sz   = 16,
  parameter int               depth     = 8,
  parameter logic [ADDR_W-1:0] id        = 8'd0,
  parameter logic [ADDR_W-1:0] broadcast = BROADCAST_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tx_valid,
  input  logic [pckg_sz-1:0] tx_data,
  output logic               tx_ready,
  output logic               pndng,
  output logic [pckg_sz-1:0] D_pop,
  input  logic               pop,
  input  logic               push,
  input  logic [pckg_sz-1:0] D_push,
  output logic               rx_valid,
  output logic [pckg_sz-1:0] rx_data,
  input  logic               rx_ready,
  output logic [7:0]         rx_drop_cnt,
  output logic               pop_err
);

  logic       w_tx_full;
  logic       w_tx_empty;
  logic       w_tx_wr;
  logic       w_rx_full;
  logic       w_rx_empty;
  logic       w_rx_deq;
  logic       w_addr_ok;
  logic       w_rx_cand;
  logic       w_rx_drop;
  logic [7:0] r_drop_cnt;
  logic       r_pop_err;

  // Ready comes from the registered count only, so a same-edge pop never opens a full FIFO.
  assign tx_ready = !w_tx_full;
  assign pndng    = !w_tx_empty;
  assign w_tx_wr  = tx_valid && tx_ready;

  bus_dev_fifo #(
    .width (pckg_sz),
    .depth (depth)
  ) u_tx_fifo (
    .clk     (clk),
    .rst     (reset),
    .i_push  (w_tx_wr),
    .i_data  (tx_data),
    .i_pop   (pop),
    .o_data  (D_pop),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty),
    .o_count ()
  );

`ifdef BUS_DEV_ADDR_FILTER_EN
  logic [MAX_PKT_W-1:0] w_push_ext;
  logic [ADDR_W-1:0]    w_push_addr;
  assign w_push_ext  = MAX_PKT_W'(D_push);
  assign w_push_addr = pkt_addr(w_push_ext, pckg_sz);
  assign w_addr_ok   = (w_push_addr == id) || (w_push_addr == broadcast);
`else
  assign w_addr_ok   = 1'b1;
`endif

  assign rx_valid  = !w_rx_empty;
  assign w_rx_deq  = rx_valid && rx_ready;
  assign w_rx_cand = push && w_addr_ok;
  // A dequeue on the same edge frees a slot, so a full FIFO only drops without one.
  assign w_rx_drop = w_rx_cand && w_rx_full && !w_rx_deq;

  bus_dev_fifo #(
    .width (pckg_sz),
    .depth (depth)
  ) u_rx_fifo (
    .clk     (clk),
    .rst     (reset),
    .i_push  (w_rx_cand),
    .i_data  (D_push),
    .i_pop   (rx_ready),
    .o_data  (rx_data),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty),
    .o_count ()
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_drop_cnt <= 8'd0;
      r_pop_err  <= 1'b0;
    end else begin
      if (w_rx_drop && (r_drop_cnt != 8'hFF)) begin
        r_drop_cnt <= r_drop_cnt + 8'd1;
      end
      if (pop && w_tx_empty) begin
        r_pop_err <= 1'b1;
      end
    end
  end

  assign rx_drop_cnt = r_drop_cnt;
  assign pop_err     = r_pop_err;

endmodule
